// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One product or quotient bit per cycle, then a sign-fix/commit cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mf_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             pause_req
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic                 is_div_q;
    logic                 sa_q;
    logic                 sb_q;
    logic                 zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;
    logic                 dz_q;

    logic                 sa_d;
    logic                 sb_d;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_tmp;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // Signed ops work on magnitudes; 0x80000000 maps to itself as unsigned.
    always_comb begin
        sa_d  = ~op[0] & rs_data[WIDTH-1];
        sb_d  = ~op[0] & rt_data[WIDTH-1];
        abs_a = sa_d ? -rs_data : rs_data;
        abs_b = sb_d ? -rt_data : rt_data;
    end

    // Datapath: shift-add for MUL, restoring shift-subtract for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
        div_tmp  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_tmp - {1'b0, b_q};
        div_ge   = ~div_diff[WIDTH];
        prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
        quo_fix  = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0]
                                 : acc_q[WIDTH-1:0];
        rem_fix  = sa_q ? -acc_q[2*WIDTH-1:WIDTH]
                        : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q    <= '0;
                        a_q      <= abs_a;
                        b_q      <= abs_b;
                        sa_q     <= sa_d;
                        sb_q     <= sb_d;
                        is_div_q <= op[1];
                        zero_q   <= op[1] && (rt_data == '0);
                        if (!op[1]) begin
                            acc_q   <= {{WIDTH{1'b0}}, abs_b};
                            state_q <= S_MUL;
                        end else if (rt_data == '0) begin
                            state_q <= S_FIX;
                        end else begin
                            acc_q   <= {{WIDTH{1'b0}}, abs_a};
                            state_q <= S_DIV;
                        end
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_MUL: begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_DIV: begin
                    acc_q <= {(div_ge ? div_diff[WIDTH-1:0]
                                      : div_tmp[WIDTH-1:0]),
                              acc_q[WIDTH-2:0], div_ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    if (zero_q) begin
                        dz_q <= 1'b1;
                    end else if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q  <= 1'b1;
                    zero_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign pause_req   = busy & (mf_req | start | hi_we | lo_we);

endmodule
